// File: rtl/demux1to8_router.sv
// Purpose: steers one beat per cycle to one of eight single-entry output channels, or broadcasts it to all eight.
// Latency: one cycle from input accept to out_valid/out_data; per-channel counters update on the pop edge.
// Backpressure: in_ready is combinational from the target channel(s) being free; a broadcast waits for all eight.
module demux1to8_router #(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    input  logic [2:0]      in_sel,
    input  logic            in_bcast,
    output logic [7:0]      out_valid,
    input  logic [7:0]      out_ready,
    output logic [8*W-1:0]  out_data,
    input  logic            cnt_clr,
    output logic [8*CW-1:0] cnt
);

    logic [7:0]    pop;
    logic [7:0]    free;
    logic [7:0]    push;
    logic [7:0]    sel_onehot;
    logic          accept;

    logic [W-1:0]  data_q [8];
    logic [CW-1:0] cnt_q  [8];

    // Handshake decode: a channel is free when empty or being drained this cycle,
    // and a broadcast needs every channel free so no beat is ever split.
    always_comb begin
        pop        = out_valid & out_ready;
        free       = ~out_valid | out_ready;
        sel_onehot = 8'b1 << in_sel;
        in_ready   = in_bcast ? (&free) : free[in_sel];
        accept     = in_valid & in_ready;
        push       = 8'h00;
        if (accept) begin
            push = in_bcast ? 8'hFF : sel_onehot;
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_chan

        // Channel register: a push refills (even while popping), otherwise a pop empties; data holds on pop.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid[i] <= 1'b0;
                data_q[i]    <= '0;
            end else if (push[i]) begin
                out_valid[i] <= 1'b1;
                data_q[i]    <= in_data;
            end else if (pop[i]) begin
                out_valid[i] <= 1'b0;
            end
        end

        // Delivered-beat counter: clear has priority over a same-edge pop; saturates at all-ones.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q[i] <= '0;
            end else if (cnt_clr) begin
                cnt_q[i] <= '0;
            end else if (pop[i] && (cnt_q[i] != {CW{1'b1}})) begin
                cnt_q[i] <= cnt_q[i] + CW'(1);
            end
        end

        assign out_data[i*W +: W] = data_q[i];
        assign cnt[i*CW +: CW]    = cnt_q[i];
    end

endmodule
